// File: rtl/disp_arbiter.sv
// Round-robin display arbiter for three requesters with a hold time,
// a one-cycle blank gap between owners, and a lamp test override.
// Ports:
//   clk_50mhz, rst (async, active-high), tick (1 Hz enable)
//   req[2:0], data0..data2 (six packed 4-bit digits), lamp_test
//   grant[2:0] one-hot, owner[1:0] (3 = none), seg_bcd_data[23:0]
module disp_arbiter #(
  parameter int         HOLD_TICKS = 3,
  parameter logic [3:0] BLANK      = 4'hF
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic [23:0] data2,
  input  logic        lamp_test,
  output logic [2:0]  grant,
  output logic [1:0]  owner,
  output logic [23:0] seg_bcd_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN      = 2'd1,
    HANDOVER = 2'd2
  } state_t;

  localparam logic [3:0]  HOLD   = 4'(HOLD_TICKS);
  localparam logic [23:0] DARK   = {6{BLANK}};
  localparam logic [23:0] LAMP   = 24'h888888;
  localparam logic [1:0]  NO_OWN = 2'd3;

  state_t      state, state_n;
  logic [2:0]  grant_n;
  logic [1:0]  owner_n;
  logic [23:0] seg_n;
  logic [3:0]  hold, hold_n;
  logic [1:0]  last, last_n;

  logic [1:0]  first, second, third;
  logic [1:0]  win;
  logic [23:0] own_data;
  logic        own_req;
  logic        others;

  // Search order starts just after the previous owner.
  always_comb begin
    case (last)
      2'd0: begin
        first  = 2'd1;
        second = 2'd2;
        third  = 2'd0;
      end
      2'd1: begin
        first  = 2'd2;
        second = 2'd0;
        third  = 2'd1;
      end
      default: begin
        first  = 2'd0;
        second = 2'd1;
        third  = 2'd2;
      end
    endcase
  end

  always_comb begin
    win = third;
    if (req[second])
      win = second;
    if (req[first])
      win = first;
  end

  always_comb begin
    case (owner)
      2'd0:    own_data = data0;
      2'd1:    own_data = data1;
      2'd2:    own_data = data2;
      default: own_data = DARK;
    endcase
  end

  assign own_req = |(req & grant);
  assign others  = |(req & ~grant);

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    seg_n   = seg_bcd_data;
    hold_n  = hold;
    last_n  = last;
    case (state)
      IDLE, HANDOVER: begin
        state_n = IDLE;
        grant_n = 3'b000;
        owner_n = NO_OWN;
        seg_n   = DARK;
        hold_n  = 4'd0;
        if (|req) begin
          state_n = OWN;
          grant_n = 3'b001 << win;
          owner_n = win;
        end
      end
      OWN: begin
        seg_n = own_data;
        if (tick && (hold < HOLD))
          hold_n = hold + 4'd1;
        // Preemption looks at the registered count only.
        if (!own_req || ((hold == HOLD) && others)) begin
          state_n = HANDOVER;
          last_n  = owner;
          grant_n = 3'b000;
          owner_n = NO_OWN;
          seg_n   = DARK;
          hold_n  = 4'd0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 3'b000;
        owner_n = NO_OWN;
        seg_n   = DARK;
        hold_n  = 4'd0;
      end
    endcase
    if (lamp_test)
      seg_n = LAMP;
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 3'b000;
      owner        <= NO_OWN;
      seg_bcd_data <= DARK;
      hold         <= 4'd0;
      last         <= 2'd2;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      owner        <= owner_n;
      seg_bcd_data <= seg_n;
      hold         <= hold_n;
      last         <= last_n;
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter: reset, rotation, hold/preempt,
// release, lamp test and asynchronous reset.
module tb_disp_arbiter;

  logic        clk_50mhz;
  logic        rst;
  logic        tick;
  logic [2:0]  req;
  logic [23:0] data0, data1, data2;
  logic        lamp_test;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic [23:0] seg_bcd_data;

  int checks = 0;
  int errors = 0;

  disp_arbiter #(.HOLD_TICKS(3), .BLANK(4'hF)) dut (
    .clk_50mhz    (clk_50mhz),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
    .data0        (data0),
    .data1        (data1),
    .data2        (data2),
    .lamp_test    (lamp_test),
    .grant        (grant),
    .owner        (owner),
    .seg_bcd_data (seg_bcd_data)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string tag, input logic [23:0] got,
                     input logic [23:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic outs(input string tag, input logic [2:0] g,
                      input logic [1:0] o, input logic [23:0] s);
    chk({tag, "_grant"}, {21'd0, grant}, {21'd0, g});
    chk({tag, "_owner"}, {22'd0, owner}, {22'd0, o});
    chk({tag, "_seg"}, seg_bcd_data, s);
  endtask

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    req       = 3'b111;
    lamp_test = 1'b0;
    data0     = 24'h111111;
    data1     = 24'h123456;
    data2     = 24'habcdef;
    step();
    outs("reset", 3'b000, 2'd3, 24'hFFFFFF);
    step();
    outs("reset_held", 3'b000, 2'd3, 24'hFFFFFF);

    req = 3'b110;
    rst = 1'b0;
    step();
    outs("first_grant", 3'b010, 2'd1, 24'hFFFFFF);
    step();
    outs("own1_data", 3'b010, 2'd1, 24'h123456);

    lamp_test = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      outs("lamp", 3'b010, 2'd1, 24'h888888);
    end
    lamp_test = 1'b0;
    step();
    outs("lamp_off", 3'b010, 2'd1, 24'h123456);
    data1 = 24'h654321;
    data0 = 24'h000000;
    step();
    outs("data_follow", 3'b010, 2'd1, 24'h654321);

    #4;
    rst = 1'b1;
    #1;
    outs("async_rst", 3'b000, 2'd3, 24'hFFFFFF);
    #2;
    req = 3'b111;
    rst = 1'b0;
    step();
    outs("after_rst", 3'b001, 2'd0, 24'hFFFFFF);

    tick = 1'b1;
    step();
    outs("tick1", 3'b001, 2'd0, 24'h000000);
    step();
    outs("tick2", 3'b001, 2'd0, 24'h000000);
    step();
    outs("tick3_same_edge", 3'b001, 2'd0, 24'h000000);
    tick = 1'b0;
    step();
    outs("handover0", 3'b000, 2'd3, 24'hFFFFFF);
    step();
    outs("rot_to1", 3'b010, 2'd1, 24'hFFFFFF);

    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      outs("hold1", 3'b010, 2'd1, 24'h654321);
    end
    tick = 1'b0;
    step();
    outs("handover1", 3'b000, 2'd3, 24'hFFFFFF);
    step();
    outs("rot_to2", 3'b100, 2'd2, 24'hFFFFFF);

    tick = 1'b1;
    step();
    outs("own2_tick", 3'b100, 2'd2, 24'habcdef);
    tick = 1'b0;
    req = 3'b000;
    step();
    outs("release2", 3'b000, 2'd3, 24'hFFFFFF);
    step();
    outs("idle", 3'b000, 2'd3, 24'hFFFFFF);

    req = 3'b111;
    step();
    outs("rot_to0", 3'b001, 2'd0, 24'hFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
